hcsr04_echo_meter: RTL and testbench
====================================

Name: hcsr04_echo_meter

Overview:
Downstream consumer of the 1 s / 10 us timebase in the HC-SR04 ultrasonic path. On each start pulse it drives the sensor TRIG pin for a fixed width and waits for the ECHO pulse. It measures the ECHO high time in microseconds and converts it to distance in millimetres. It presents a one-cycle valid strobe with distance, raw echo time and a timeout flag to the display/UART stage.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; CYCLES_PER_US = CLK_FREQ_HZ/1_000_000 (50).
TRIG_US, 10, TRIG high width in us.
RISE_TIMEOUT_US, 5000, max wait from TRIG fall to ECHO rise.
MAX_ECHO_US, 38000, max ECHO high time; beyond this the result is a timeout.
DIST_MULT, 11239, Q0.16 factor for us->mm (0.1715 mm/us = 343 m/s round trip).

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle measurement request (flag_1s)
echo  in  1  raw asynchronous sensor ECHO pin
trig  out  1  sensor TRIG pin, registered
busy  out  1  high from accepted start until dist_valid
dist_valid  out  1  one-cycle result strobe
dist_mm  out  16  distance in mm, held until next dist_valid
echo_us  out  16  measured ECHO width in us, held
err_timeout  out  1  qualifies dist_valid: 1 = no echo or echo too long

Behaviour:
- Reset (async, rstn=0): state IDLE; trig=0, busy=0, dist_valid=0, dist_mm=0, echo_us=0, err_timeout=0; all counters 0.
- echo is passed through a 2-flop synchronizer (echo_s). Edges are detected on echo_s against its delayed copy.
- A us-tick counter counts 0..CYCLES_PER_US-1 and emits tick on the terminal count. It is cleared on entry to TRIG and on the echo_s rising edge.
- FSM states and transitions:
  - IDLE: start=1 -> TRIG. busy rises the cycle after start.
  - TRIG: trig=1 for exactly TRIG_US*CYCLES_PER_US cycles (500). Then trig=0 and go to WAIT_RISE with the us counter cleared.
  - WAIT_RISE: echo_s rising edge -> MEASURE with us counter=0. Counter reaching RISE_TIMEOUT_US -> DONE with err_timeout=1, echo_us=0, dist_mm=0.
  - MEASURE: echo_us_cnt increments on each tick while echo_s=1. On falling edge, capture the floor count of whole us -> CALC. If the count reaches MAX_ECHO_US -> DONE with err_timeout=1, echo_us=MAX_ECHO_US, dist_mm=16'hFFFF.
  - CALC: prod = echo_us_cnt * DIST_MULT (32-bit, registered); dist_mm = prod[31:16] (truncate). err_timeout=0 -> DONE.
  - DONE: dist_valid=1 for one cycle, busy=0 the same cycle -> IDLE.
- start while busy is ignored (no queueing). start in the same cycle as DONE is ignored.
- Echo already high when WAIT_RISE is entered gives no rising edge; it ends in timeout unless it falls and rises again.
- Echo glitch in IDLE/TRIG is ignored.
- Latency: echo_s falling edge to dist_valid = 2 cycles (CALC, DONE), plus 2 synchronizer cycles from the pin.
- Reset mid-measurement returns to IDLE with trig=0 immediately (asynchronous).

Optional Feature:
- Macro: HCSR04_ECHO_FILTER_EN.
- Defined: a 3-tap majority filter follows the synchronizer. Single-cycle echo glitches are rejected. Both edges are delayed equally (+2 cycles), so the measured width is unchanged.
- Undefined: echo_s is used directly.

Decomposition:
- Package hcsr04_pkg holds:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, CALC, DONE);
  - default constants TRIG_US, RISE_TIMEOUT_US, MAX_ECHO_US, DIST_MULT;
  - width localparams (US_W=16, PROD_W=32).
- One natural sub-module: hcsr04_us_tick, the clearable CYCLES_PER_US divider producing a tick.

Test Plan:
1. Reset with echo=0, then start pulse -> trig high exactly 500 cycles, busy=1 the next cycle.
2. Echo high 1000 us after trig -> dist_valid with echo_us=1000, dist_mm=171, err_timeout=0.
3. Echo high 5800 us -> echo_us=5800, dist_mm=994, err_timeout=0.
4. No echo -> dist_valid 5000 us after trig falls, with err_timeout=1, echo_us=0, dist_mm=0.
5. Echo held high 40000 us -> at 38000 us: dist_valid, err_timeout=1, echo_us=38000, dist_mm=16'hFFFF. A second start during the measurement is ignored.
6. rstn asserted mid-MEASURE -> trig=0, busy=0 immediately. After release, a new start measures normally. With HCSR04_ECHO_FILTER_EN, a 1-cycle echo glitch in WAIT_RISE does not start a measurement.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared types and default constants for the HC-SR04 echo meter.
package hcsr04_pkg;

    localparam int US_W   = 16;
    localparam int PROD_W = 32;

    localparam int TRIG_US         = 10;
    localparam int RISE_TIMEOUT_US = 5000;
    localparam int MAX_ECHO_US     = 38000;
    localparam int DIST_MULT       = 11239;  // Q0.16 of 0.1715 mm/us

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        CALC      = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/hcsr04_echo_meter_us_tick.sv
// Clearable clock divider: one-cycle tick every CYCLES clocks.
module hcsr04_us_tick #(
    parameter int CYCLES = 50
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/hcsr04_echo_meter.sv
// HC-SR04 trigger/echo timer with us->mm conversion.
// Define HCSR04_ECHO_FILTER_EN to add a 3-tap majority glitch filter on ECHO.
module hcsr04_echo_meter #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int TRIG_US         = hcsr04_pkg::TRIG_US,
    parameter int RISE_TIMEOUT_US = hcsr04_pkg::RISE_TIMEOUT_US,
    parameter int MAX_ECHO_US     = hcsr04_pkg::MAX_ECHO_US,
    parameter int DIST_MULT       = hcsr04_pkg::DIST_MULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        dist_valid,
    output logic [15:0] dist_mm,
    output logic [15:0] echo_us,
    output logic        err_timeout
);
    import hcsr04_pkg::*;

    localparam int CYCLES_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int TRIG_CYC      = TRIG_US * CYCLES_PER_US;
    localparam int TC_W          = $clog2(TRIG_CYC + 1);

    localparam logic [US_W:0]     RISE_C = (US_W+1)'(RISE_TIMEOUT_US);
    localparam logic [US_W:0]     MAX_C  = (US_W+1)'(MAX_ECHO_US);
    localparam logic [PROD_W-1:0] MULT   = PROD_W'(DIST_MULT);

    state_t            state;
    logic [1:0]        sync;
    logic              echo_s, echo_d, echo_rise, echo_fall;
    logic              tick, tick_clr;
    logic [TC_W-1:0]   trig_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [US_W:0]     cnt_nx;
    logic [PROD_W-1:0] prod;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '0;
        else       sync <= {sync[0], echo};
    end

`ifdef HCSR04_ECHO_FILTER_EN
    logic [2:0] taps;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) taps <= '0;
        else       taps <= {taps[1:0], sync[1]};
    end
    assign echo_s = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
`else
    assign echo_s = sync[1];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) echo_d <= 1'b0;
        else       echo_d <= echo_s;
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    // Clearing at TRIG entry keeps the us grid aligned with the trig fall.
    assign tick_clr = (state == IDLE && start) || (state == WAIT_RISE && echo_rise);

    hcsr04_us_tick #(.CYCLES(CYCLES_PER_US)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (tick_clr),
        .tick (tick)
    );

    // A tick landing on the fall cycle still closes a full microsecond.
    assign cnt_nx = {1'b0, us_cnt} + {{US_W{1'b0}}, tick};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            trig        <= 1'b0;
            busy        <= 1'b0;
            dist_valid  <= 1'b0;
            dist_mm     <= '0;
            echo_us     <= '0;
            err_timeout <= 1'b0;
            trig_cnt    <= '0;
            us_cnt      <= '0;
            prod        <= '0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= TRIG;
                    trig     <= 1'b1;
                    busy     <= 1'b1;
                    trig_cnt <= '0;
                end
                TRIG: begin
                    if (trig_cnt == TC_W'(TRIG_CYC - 1)) begin
                        trig   <= 1'b0;
                        state  <= WAIT_RISE;
                        us_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        state  <= MEASURE;
                        us_cnt <= '0;
                    end else if (cnt_nx == RISE_C) begin
                        state       <= DONE;
                        err_timeout <= 1'b1;
                        echo_us     <= '0;
                        dist_mm     <= '0;
                        dist_valid  <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        us_cnt <= cnt_nx[US_W-1:0];
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        state  <= CALC;
                        us_cnt <= cnt_nx[US_W-1:0];
                        prod   <= PROD_W'(cnt_nx[US_W-1:0]) * MULT;
                    end else if (cnt_nx == MAX_C) begin
                        state       <= DONE;
                        err_timeout <= 1'b1;
                        echo_us     <= MAX_C[US_W-1:0];
                        dist_mm     <= 16'hFFFF;
                        dist_valid  <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        us_cnt <= cnt_nx[US_W-1:0];
                    end
                end
                CALC: begin
                    state       <= DONE;
                    echo_us     <= us_cnt;
                    dist_mm     <= US_W'(prod >> 16);
                    err_timeout <= 1'b0;
                    dist_valid  <= 1'b1;
                    busy        <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hcsr04_echo_meter.sv
// Scoreboard bench for hcsr04_echo_meter at 2 cycles/us with shortened timeouts.
module tb_hcsr04_echo_meter;
    localparam int CPU      = 2;
    localparam int TRIG_CYC = 10 * CPU;

    logic        clk = 1'b0;
    logic        rstn, start, echo;
    logic        trig, busy, dist_valid, err_timeout;
    logic [15:0] dist_mm, echo_us;

    typedef struct {
        int us;
        int mm;
        int err;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    hcsr04_echo_meter #(
        .CLK_FREQ_HZ     (2_000_000),
        .TRIG_US         (10),
        .RISE_TIMEOUT_US (2000),
        .MAX_ECHO_US     (8000),
        .DIST_MULT       (11239)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .dist_valid  (dist_valid),
        .dist_mm     (dist_mm),
        .echo_us     (echo_us),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstn && dist_valid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got dist_valid with echo_us=%0d, expected none", echo_us);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("echo_us", int'(echo_us), e.us);
                chk("dist_mm", int'(dist_mm), e.mm);
                chk("err_timeout", int'(err_timeout), e.err);
            end
        end
    end

    task automatic run(input int delay, input int width, input int start_at, input int glitch_at);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        chk("trig_rise", int'(trig), 1);
        n = 0;
        while (trig && n < 100000) begin
            @(negedge clk);
            n++;
        end
        chk("trig_width", n, TRIG_CYC);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1 echo = (i == glitch_at);
        end
        @(posedge clk); #1 echo = (width > 0);
        for (int i = 0; i < width; i++) begin
            @(posedge clk); #1 start = (i == start_at);
        end
        echo  = 1'b0;
        start = 1'b0;
        n = 0;
        while (busy && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) chk("busy_release_timeout", n, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; echo = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_dist", int'(dist_mm), 0);
        chk("rst_echo_us", int'(echo_us), 0);
        chk("rst_err", int'(err_timeout), 0);
        @(posedge clk); #1 rstn = 1'b1;

        q.push_back('{1000, 171, 0});   run(10, 2000, -1, -1);
        q.push_back('{5800, 994, 0});   run(10, 11600, -1, -1);
        q.push_back('{37, 6, 0});       run(10, 75, -1, -1);
        q.push_back('{0, 0, 1});        run(10, 0, -1, -1);
        // Echo held past the limit; the mid-measurement start must be dropped.
        q.push_back('{8000, 65535, 1}); run(10, 18000, 4000, -1);
        chk("idle_after_long_echo", int'(busy), 0);

        // Asynchronous reset in the middle of a measurement.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(busy && !trig) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_rise", int'(n < 1000), 1);
        @(posedge clk); #1 echo = 1'b1;
        repeat (500) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("arst_trig", int'(trig), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_echo_us", int'(echo_us), 0);
        chk("arst_dist", int'(dist_mm), 0);
        @(posedge clk); #1 echo = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        q.push_back('{1000, 171, 0});   run(10, 2000, -1, -1);
`ifdef HCSR04_ECHO_FILTER_EN
        q.push_back('{1000, 171, 0});   run(100, 2000, -1, 20);
`endif
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
